// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a two-word LI sequence and a data-mem timeout.
// Optional CTRL_PERF_CNT_EN adds saturating retire_cnt/stall_cnt outputs.
module ctrl_seq #(
    parameter int IW     = 7,
    parameter int OPW    = 3,
    parameter int AOPW   = 3,
    parameter int RDW    = 2,
    parameter int MEM_TO = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    input  logic            mem_ready,
    input  logic            zero,
    input  logic            halt_req,
    output logic            IRLoad,
    output logic            PCEn,
    output logic            PCSrc,
    output logic            Branch,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic            li,
    output logic            sb,
    output logic [AOPW-1:0] ALUOp,
    output logic [RDW-1:0]  RegDst,
    output logic            mem_err,
    output logic            halted
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]     retire_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    // state  | meaning
    // FETCH  | wait for instr_valid / halt_req
    // DECODE | LI prefix, LI immediate, or dispatch
    // EXEC   | ALU op or beq resolve
    // MEM    | data-mem access, stalls on mem_ready
    // WB     | register write-back
    // HALT   | parked until reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int WCW = $clog2(MEM_TO + 1);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(1);
    localparam logic [OPW-1:0] OP_SB  = OPW'(2);
    localparam logic [OPW-1:0] OP_LBU = OPW'(3);

    state_t         state, state_nxt;
    logic [IW-1:0]  ir;
    logic           li_pend, li_pend_nxt;
    logic [RDW-1:0] rd_q, rd_nxt;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic           mem_err_nxt;
    logic [OPW-1:0] opc;
    logic           is_prefix;

    assign opc       = ir[IW-1 -: OPW];
    assign is_prefix = (ir[IW-1:RDW] == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            li_pend  <= 1'b0;
            rd_q     <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            li_pend  <= li_pend_nxt;
            rd_q     <= rd_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err_nxt;
            if (IRLoad) ir <= instr;
        end
    end

    always_comb begin
        state_nxt   = state;
        li_pend_nxt = li_pend;
        rd_nxt      = rd_q;
        wait_nxt    = wait_cnt;
        mem_err_nxt = mem_err;
        IRLoad      = 1'b0;
        PCEn        = 1'b0;
        PCSrc       = 1'b0;
        Branch      = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        li          = 1'b0;
        sb          = 1'b0;
        ALUOp       = '1;
        RegDst      = rd_q;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (instr_valid) begin
                    IRLoad    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (li_pend) begin
                    ALUSrc      = 1'b1;
                    RegWrite    = 1'b1;
                    ALUOp       = '0;
                    li_pend_nxt = 1'b0;
                    rd_nxt      = '0;
                    PCEn        = 1'b1;
                    state_nxt   = S_FETCH;
                end else if (is_prefix) begin
                    // destination is shown now and held in rd_q until the immediate word retires
                    li          = 1'b1;
                    RegDst      = ir[RDW-1:0];
                    rd_nxt      = ir[RDW-1:0];
                    li_pend_nxt = 1'b1;
                    PCEn        = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUOp = AOPW'(opc);
                if (opc == OP_BEQ) begin
                    Branch    = 1'b1;
                    PCEn      = 1'b1;
                    PCSrc     = zero;
                    state_nxt = S_FETCH;
                end else if (opc == OP_SB || opc == OP_LBU) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (opc == OP_SB) begin
                    MemWrite = 1'b1;
                    sb       = 1'b1;
                end else begin
                    MemtoReg = 1'b1;
                end
                if (mem_ready) begin
                    wait_nxt = '0;
                    if (opc == OP_SB) begin
                        PCEn      = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == WCW'(MEM_TO)) begin
                    // abandon without retiring; the same instruction is fetched again
                    mem_err_nxt = 1'b1;
                    wait_nxt    = '0;
                    state_nxt   = S_FETCH;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = (opc == OP_LBU);
                PCEn      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = (state == S_FETCH && !instr_valid) || (state == S_MEM && !mem_ready);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (PCEn && retire_cnt != 16'hFFFF) retire_cnt <= retire_cnt + 16'd1;
            if (stall_evt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed and random instructions checked against a per-instruction
// timing/strobe model derived from the sequencing rules (latency by class, LI pairing, timeout).
module tb_ctrl_seq;
    localparam int MEM_TO = 15;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [6:0] instr;
    logic       instr_valid, mem_ready, zero, halt_req;
    logic       IRLoad, PCEn, PCSrc, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, li, sb;
    logic [2:0] ALUOp;
    logic [1:0] RegDst;
    logic       mem_err, halted;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retire_cnt, stall_cnt;
`endif

    ctrl_seq #(.MEM_TO(MEM_TO)) dut (
        .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .zero(zero), .halt_req(halt_req),
        .IRLoad(IRLoad), .PCEn(PCEn), .PCSrc(PCSrc), .Branch(Branch),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .li(li), .sb(sb), .ALUOp(ALUOp), .RegDst(RegDst), .mem_err(mem_err), .halted(halted)
`ifdef CTRL_PERF_CNT_EN
        , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit       m_li_pend = 1'b0;
    bit [1:0] m_rd = 2'b00;
    bit       m_err = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_strobes"},
            {IRLoad, PCEn, PCSrc, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, li, sb, mem_err, halted},
            16'h0);
        chk({tag, "_aluop"}, ALUOp, 3'b111);
        chk({tag, "_regdst"}, RegDst, 2'b00);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("idle_irload", IRLoad, 1'b0);
            chk("idle_pcen", PCEn, 1'b0);
            tick();
        end
    endtask

    // Called just after a rising edge with the sequencer in FETCH; returns the same way.
    // w = MEM wait cycles before mem_ready; w > MEM_TO means ready never arrives.
    task automatic run_instr(input logic [6:0] ins, input int w, input bit z);
        logic [2:0] op;
        bit imm, pre, is_mem, is_beq, is_sb, is_lbu, is_alu, timeout;
        int pc_cyc, last;
        logic [7:0] e_strb;
        logic [1:0] e_rd;
        op      = ins[6:4];
        imm     = m_li_pend;
        pre     = !imm && (ins[6:2] == 5'd0);
        is_beq  = !imm && !pre && op == 3'd1;
        is_sb   = !imm && !pre && op == 3'd2;
        is_lbu  = !imm && !pre && op == 3'd3;
        is_mem  = is_sb || is_lbu;
        is_alu  = !imm && !pre && !is_beq && !is_mem;
        timeout = is_mem && (w > MEM_TO);
        // cycle index (FETCH accept = 0) at which PCEn should pulse
        pc_cyc  = (imm || pre) ? 1 : is_beq ? 2 : is_sb ? 3 + w : is_lbu ? 4 + w : 3;
        last    = timeout ? 3 + MEM_TO + 1 : pc_cyc;
        // {PCSrc, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, li, sb}
        e_strb  = {is_beq & z, is_beq, is_lbu, is_sb, imm, imm | is_lbu | is_alu, pre, is_sb};
        e_rd    = pre ? ins[1:0] : m_rd;

        instr       = ins;
        instr_valid = 1'b1;
        zero        = z;
        mem_ready   = is_mem ? 1'b0 : 1'($urandom);
        for (int c = 0; c <= last; c++) begin
            @(negedge Clk);
            if (c == 0) chk("irload", IRLoad, 1'b1);
            if (c == 2 && !imm && !pre) chk("aluop_exec", ALUOp, op);
            if (timeout && c == last) begin
                chk("timeout_pcen", PCEn, 1'b0);
                chk("timeout_mem_err", mem_err, 1'b1);
            end else if (c == pc_cyc) begin
                chk("pcen", PCEn, 1'b1);
                chk("strobes", {PCSrc, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, li, sb}, e_strb);
                chk("regdst", RegDst, e_rd);
                chk("mem_err_hold", mem_err, m_err);
                if (imm) chk("aluop_imm", ALUOp, 3'b000);
                if (is_beq) chk("aluop_beq", ALUOp, 3'b001);
            end else begin
                chk("no_early_pcen", PCEn, 1'b0);
            end
            tick();
            instr_valid = 1'b0;
            instr       = 7'($urandom);
            mem_ready   = is_mem ? (c + 1 == 3 + w) : 1'($urandom);
        end
        mem_ready = 1'b0;
        if (imm) begin
            m_li_pend = 1'b0;
            m_rd      = 2'b00;
        end
        if (pre) begin
            m_li_pend = 1'b1;
            m_rd      = ins[1:0];
        end
        if (timeout) m_err = 1'b1;
    endtask

    task automatic model_reset();
        m_li_pend = 1'b0;
        m_rd      = 2'b00;
        m_err     = 1'b0;
    endtask

    initial begin
        logic [6:0] ins;
        int cls;
        Reset       = 1'b0;
        instr       = 7'd0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        zero        = 1'b0;
        halt_req    = 1'b0;
        #3;
        check_reset_outs("reset");
        @(negedge Clk);
        Reset = 1'b1;
        tick();

        run_instr(7'b0000110, 0, 1'b0);      // add
        run_instr(7'b0000010, 0, 1'b0);      // LI prefix, rd=2
        run_instr(7'b1011011, 0, 1'b0);      // LI immediate word
        run_instr(7'b0110101, 3, 1'b0);      // lbu, 3 waits
        run_instr(7'b0100000, 100, 1'b0);    // sb, never ready
        run_instr(7'b0010000, 0, 1'b1);      // beq taken
        run_instr(7'b0010000, 0, 1'b0);      // beq not taken
        run_instr(7'b0101001, MEM_TO, 1'b0); // sb, ready on last allowed cycle
        run_instr(7'b0110011, 0, 1'b0);      // lbu, no wait
        idle(2);

        for (int n = 0; n < 40; n++) begin
            idle($urandom_range(0, 2));
            cls = $urandom_range(0, 7);
            if (cls == 0) begin
                ins = {5'b00000, 2'($urandom)};
            end else begin
                ins = 7'($urandom);
                if (ins[6:2] == 5'd0) ins[2] = 1'b1;
            end
            run_instr(ins, $urandom_range(0, 5), 1'($urandom));
        end

        // reset while stalled in MEM
        instr       = 7'b0100001;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check_reset_outs("reset_mem");
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        run_instr(7'b1100110, 0, 1'b0);      // and

        // reset between LI prefix and immediate word
        run_instr(7'b0000001, 0, 1'b0);
        Reset = 1'b0;
        #1;
        check_reset_outs("reset_li");
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        run_instr(7'b1000101, 0, 1'b0);      // xor decodes normally

        // halt_req wins over instr_valid
        instr       = 7'b0000110;
        instr_valid = 1'b1;
        halt_req    = 1'b1;
        @(negedge Clk);
        chk("halt_no_irload", IRLoad, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("halted", halted, 1'b1);
            chk("halt_pcen", PCEn, 1'b0);
            chk("halt_irload", IRLoad, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
